// File: rtl/sequence_controller_if.sv
// Control bundle between the multi-cycle datapath and its sequence controller.
// The datapath side supplies instruction fields; the controller drives every control line.
interface sequence_controller_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic [2:0] ALU_OP;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       ExtOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] State;

  modport master (
    output Opcode, Funct,
    input  ALU_OP, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
           MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB,
           PCSource, State
  );

  modport slave (
    input  Opcode, Funct,
    output ALU_OP, PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite,
           MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB,
           PCSource, State
  );
endinterface

// File: rtl/sequence_controller.sv
// Moore-style multi-cycle control FSM for a small MIPS-like datapath.
// Outputs decode the current state (plus Opcode in I_EXEC and BRANCH).
module sequence_controller (
  input logic                  clk,
  input logic                  rst,
  sequence_controller_if.slave bus
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] R_EXEC    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] BRANCH    = 4'd8;
  localparam logic [3:0] JUMP      = 4'd9;
  localparam logic [3:0] I_EXEC    = 4'd10;
  localparam logic [3:0] I_WB      = 4'd11;
  localparam logic [3:0] JR        = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [3:0] state;
  logic [3:0] next_state;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW:   next_state = MEM_ADDR;
          OP_RTYPE:       next_state = (bus.Funct == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_J:           next_state = JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_XORI: next_state = I_EXEC;
          default:        next_state = FETCH;
        endcase
      end
      MEM_ADDR: next_state = (bus.Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ: next_state = MEM_WB;
      R_EXEC:   next_state = R_WB;
      I_EXEC:   next_state = I_WB;
      default:  next_state = FETCH;
    endcase
  end

  assign bus.State = state;

  always_comb begin
    bus.ALU_OP      = 3'b000;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNE    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ExtOp       = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = 1'b1;
      end
      DECODE:   bus.ALUSrcB = 2'b11;
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALU_OP  = 3'b010;
      end
      R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALU_OP      = 3'b001;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.BranchNE    = (bus.Opcode == OP_BNE);
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      I_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (bus.Opcode)
          OP_SLTI: bus.ALU_OP = 3'b011;
          OP_ANDI: bus.ALU_OP = 3'b100;
          OP_ORI:  bus.ALU_OP = 3'b101;
          OP_XORI: bus.ALU_OP = 3'b110;
          default: bus.ALU_OP = 3'b000;
        endcase
        bus.ExtOp = (bus.Opcode == OP_ANDI) || (bus.Opcode == OP_ORI) ||
                    (bus.Opcode == OP_XORI);
      end
      I_WB:     bus.RegWrite = 1'b1;
      JR: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
      end
      default: ;
    endcase
    // Architectural write enables are held off for as long as reset is applied.
    if (rst) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
    end
  end

endmodule

// File: doc/sequence_controller.md
SEQUENCE_CONTROLLER -- requirements
Module: sequence_controller

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state changes on the rising edge.
REQ-002 SHALL have rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have Opcode, input, 6, bits [31:26] of the instruction register; stable from DECODE onward.
REQ-004 SHALL have Funct, input, 6, bits [5:0] of the instruction register.
REQ-005 SHALL have ALU_OP, output, 3, the ALU_OP command to the ALU controller (ctrl): 000 add, 001 sub, 010 R-type (use Funct), 011 slt, 100 and, 101 or, 110 xor.
REQ-006 SHALL have these 1-bit outputs: PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, ExtOp (1 = zero-extend immediate).
REQ-007 SHALL have ALUSrcB, output, 2: 00 regB, 01 constant 4, 10 extended immediate, 11 immediate shifted left by 2.
REQ-008 SHALL have PCSource, output, 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 regA.
REQ-009 SHALL have State, output, 4, current state code for debug.

Function
REQ-010 SHALL be a Moore FSM: outputs decode the current state only, plus Opcode in I_EXEC and BRANCH; every output not listed for a state is 0.
REQ-011 SHALL use these state codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, JR 12; codes 13-15 go to FETCH on the next edge.
REQ-012 SHALL drive in FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_OP=000, PCSource=00, PCWrite=1; next state DECODE.
REQ-013 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALU_OP=000.
REQ-014 SHALL take these DECODE transitions:
- 100011 (lw) or 101011 (sw) -> MEM_ADDR
- 000000 with Funct 001000 -> JR
- 000000 with any other Funct -> R_EXEC
- 000100 (beq) or 000101 (bne) -> BRANCH
- 000010 (j) -> JUMP
- 001000, 001001, 001010, 001100, 001101, 001110 -> I_EXEC
- any other opcode -> FETCH (executed as a NOP, no write enables)
REQ-015 SHALL drive in MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_OP=000; next state MEM_READ for lw, MEM_WRITE for sw.
REQ-016 SHALL drive in MEM_READ: MemRead=1, IorD=1; next state MEM_WB.
REQ-017 SHALL drive in MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-018 SHALL drive in MEM_WRITE: MemWrite=1, IorD=1; next state FETCH.
REQ-019 SHALL drive in R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_OP=010; next state R_WB.
REQ-020 SHALL drive in R_WB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-021 SHALL drive in BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_OP=001, PCWriteCond=1, PCSource=01, BranchNE=(Opcode==000101); next state FETCH.
REQ-022 SHALL drive in JUMP: PCWrite=1, PCSource=10; in JR: PCWrite=1, PCSource=11; next state FETCH for both.
REQ-023 SHALL drive in I_EXEC: ALUSrcA=1, ALUSrcB=10.
- ALU_OP: 000 for addi/addiu, 011 slti, 100 andi, 101 ori, 110 xori.
- ExtOp=1 for andi/ori/xori.
- Next state I_WB.
REQ-024 SHALL drive in I_WB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-025 SHALL give these cycle counts per instruction, including FETCH: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3, jr 3, undefined 2.
REQ-026 SHALL assert at most one of MemRead/MemWrite, and never assert PCWrite and PCWriteCond together.

Reset
REQ-027 SHALL load State=FETCH on the rising edge where rst=1, regardless of the current state; this includes reset in mid-instruction.
REQ-028 SHALL force PCWrite, PCWriteCond, MemWrite, RegWrite and IRWrite to 0 while rst=1; after reset, the first cycle with rst=0 is a full FETCH.

Verification
REQ-029 SHALL cover lw (Opcode 100011): State 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; ALU_OP=000 in states 0, 1 and 2.
REQ-030 SHALL cover R-type add (000000/100000): State 0,1,6,7,0; ALU_OP=010 in state 6; RegWrite=1 and RegDst=1 in state 7. With Funct 001000: State 0,1,12,0 with PCSource=11 and PCWrite=1, and RegWrite never asserted.
REQ-031 SHALL cover beq (000100) and bne (000101): State 0,1,8,0; ALU_OP=001, PCWriteCond=1, PCSource=01; BranchNE=0 for beq and 1 for bne.
REQ-032 SHALL cover each I-type opcode: ALU_OP in state 10 per REQ-023; ExtOp=1 only for 001100, 001101 and 001110; RegWrite=1 in state 11.
REQ-033 SHALL cover undefined Opcode 111111: State 0,1,0; MemWrite, RegWrite, PCWriteCond and PCWrite stay 0 in state 1.
REQ-034 SHALL cover reset mid-operation: assert rst during MEM_READ of lw -> State=0 on the next edge, RegWrite never asserts for that lw, write enables are 0 while rst=1.
